// File: rtl/ps2_line_assembler_if.sv
// Keyboard-to-line-assembler bus: character strobe in, line/edit state out.
interface ps2_line_assembler_if #(
  parameter int LINE_CHARS = 32
);
  localparam int LW = 8 * LINE_CHARS;
  localparam int CW = $clog2(LINE_CHARS + 1);

  logic [7:0]    char_in;
  logic          char_valid;
  logic [LW-1:0] line_out;
  logic          line_ready;
  logic [LW-1:0] edit_line;
  logic [CW-1:0] cursor;
  logic          overflow;

  // Keyboard decoder side: drives characters, observes the assembled line.
  modport master (
    output char_in, char_valid,
    input  line_out, line_ready, edit_line, cursor, overflow
  );

  // Line assembler side.
  modport slave (
    input  char_in, char_valid,
    output line_out, line_ready, edit_line, cursor, overflow
  );
endinterface

// File: rtl/ps2_line_assembler.sv
// Builds an editable command line from keyboard characters and publishes it
// as a left-justified packed line with a one-cycle ready pulse on Enter.
module ps2_line_assembler #(
  parameter int         LINE_CHARS = 32,
  parameter logic [7:0] PAD_CHAR   = 8'h00,
  parameter int         UPCASE     = 1
) (
  input logic                  i_clock,
  input logic                  i_resetn,
  ps2_line_assembler_if.slave  bus
);
  localparam int LW = 8 * LINE_CHARS;
  localparam int CW = $clog2(LINE_CHARS + 1);

  localparam logic [0:0] ST_EDIT   = 1'b0;
  localparam logic [0:0] ST_COMMIT = 1'b1;

  localparam logic [LW-1:0] PAD_LINE = {LINE_CHARS{PAD_CHAR}};
  localparam logic [CW-1:0] CUR_MAX  = CW'(LINE_CHARS);

  logic [0:0]    r_state;
  logic [LW-1:0] r_line_out;
  logic [LW-1:0] r_edit_line;
  logic [CW-1:0] r_cursor;
  logic          r_overflow;

  logic [0:0]    w_state_next;
  logic [LW-1:0] w_line_out_next;
  logic [LW-1:0] w_edit_next;
  logic [CW-1:0] w_cursor_next;
  logic          w_overflow_next;

  logic [7:0]    w_char;
  logic          w_is_print;
  logic          w_is_bs;
  logic          w_is_enter;
  logic          w_is_esc;
  logic [CW-1:0] w_cursor_dec;

  assign w_is_print   = (bus.char_in >= 8'h20) && (bus.char_in <= 8'h7E);
  assign w_is_bs      = (bus.char_in == 8'h08);
  assign w_is_enter   = (bus.char_in == 8'h0D) || (bus.char_in == 8'h0A);
  assign w_is_esc     = (bus.char_in == 8'h1B);
  assign w_char       = ((UPCASE != 0) && (bus.char_in >= 8'h61) && (bus.char_in <= 8'h7A))
                        ? (bus.char_in - 8'h20) : bus.char_in;
  assign w_cursor_dec = r_cursor - CW'(1);

  // Next-state decode: classify the incoming character and edit the buffer.
  // COMMIT lasts exactly one cycle, and characters are still accepted during it.
  always_comb begin
    w_state_next    = ST_EDIT;
    w_line_out_next = r_line_out;
    w_edit_next     = r_edit_line;
    w_cursor_next   = r_cursor;
    w_overflow_next = r_overflow;
    if (bus.char_valid) begin
      if (w_is_print) begin
        if (r_cursor < CUR_MAX) begin
          for (int i = 0; i < LINE_CHARS; i++) begin
            if (CW'(i) == r_cursor) w_edit_next[LW-1-8*i -: 8] = w_char;
          end
          w_cursor_next = r_cursor + CW'(1);
        end else begin
          w_overflow_next = 1'b1;
        end
      end else if (w_is_bs) begin
        if (r_cursor != '0) begin
          for (int i = 0; i < LINE_CHARS; i++) begin
            if (CW'(i) == w_cursor_dec) w_edit_next[LW-1-8*i -: 8] = PAD_CHAR;
          end
          w_cursor_next = w_cursor_dec;
        end
      end else if (w_is_enter) begin
        // An overflowed line is discarded rather than published truncated.
        if (r_overflow) begin
          w_edit_next     = PAD_LINE;
          w_cursor_next   = '0;
          w_overflow_next = 1'b0;
        end else if (r_cursor != '0) begin
          w_line_out_next = r_edit_line;
          w_state_next    = ST_COMMIT;
          w_edit_next     = PAD_LINE;
          w_cursor_next   = '0;
        end
      end else if (w_is_esc) begin
        w_edit_next     = PAD_LINE;
        w_cursor_next   = '0;
        w_overflow_next = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state     <= ST_EDIT;
      r_line_out  <= PAD_LINE;
      r_edit_line <= PAD_LINE;
      r_cursor    <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_line_out  <= w_line_out_next;
      r_edit_line <= w_edit_next;
      r_cursor    <= w_cursor_next;
      r_overflow  <= w_overflow_next;
    end
  end

  assign bus.line_out   = r_line_out;
  assign bus.line_ready = (r_state == ST_COMMIT);
  assign bus.edit_line  = r_edit_line;
  assign bus.cursor     = r_cursor;
  assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_ps2_line_assembler.sv
// Self-checking bench for ps2_line_assembler: directed scenarios followed by
// random keystrokes, compared against a queue-based model of the edit line.
module tb_ps2_line_assembler;
  typedef logic [7:0] u8;

  logic clk;
  logic resetn;
  int   total;
  int   bad;

  ps2_line_assembler_if #(.LINE_CHARS(32)) bus ();

  ps2_line_assembler #(.LINE_CHARS(32), .PAD_CHAR(8'h00), .UPCASE(1)) dut (
    .i_clock  (clk),
    .i_resetn (resetn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the line as a queue of characters.
  u8            m_q[$];
  logic         m_ovf;
  logic [255:0] m_line;
  logic         m_ready;

  function automatic logic [255:0] pack(input u8 q[$]);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < q.size(); i++) r[255-8*i -: 8] = q[i];
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf   = 1'b0;
    m_line  = '0;
    m_ready = 1'b0;
  endtask

  task automatic model_apply(input u8 c);
    u8 uc;
    m_ready = 1'b0;
    uc = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    if (c >= 8'h20 && c <= 8'h7E) begin
      if (m_q.size() < 32) m_q.push_back(uc);
      else m_ovf = 1'b1;
    end else if (c == 8'h08) begin
      if (m_q.size() > 0) void'(m_q.pop_back());
    end else if (c == 8'h0D || c == 8'h0A) begin
      if (m_ovf) begin
        m_q.delete();
        m_ovf = 1'b0;
      end else if (m_q.size() > 0) begin
        m_line  = pack(m_q);
        m_ready = 1'b1;
        m_q.delete();
      end
    end else if (c == 8'h1B) begin
      m_q.delete();
      m_ovf = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".line_out"},   bus.line_out,             m_line);
    chk({tag, ".line_ready"}, 256'(bus.line_ready),     256'(m_ready));
    chk({tag, ".edit_line"},  bus.edit_line,            pack(m_q));
    chk({tag, ".cursor"},     256'(bus.cursor),         256'(m_q.size()));
    chk({tag, ".overflow"},   256'(bus.overflow),       256'(m_ovf));
  endtask

  // One character strobe for exactly one clock edge, then check.
  task automatic send(input u8 c, input string tag);
    @(negedge clk);
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    @(posedge clk);
    model_apply(c);
    #1;
    bus.char_valid = 1'b0;
    $display("tx %s char=%h cursor=%0d ready=%b ovf=%b", tag, c, bus.cursor, bus.line_ready, bus.overflow);
    check_all(tag);
  endtask

  task automatic send_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) send(u8'(s[i]), tag);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    bus.char_valid = 1'b0;
    @(posedge clk);
    m_ready = 1'b0;
    #1;
    $display("tx %s idle cursor=%0d ready=%b", tag, bus.cursor, bus.line_ready);
    check_all(tag);
  endtask

  initial begin
    u8  c;
    int r;
    total = 0;
    bad   = 0;
    bus.char_in    = 8'h00;
    bus.char_valid = 1'b0;
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    resetn = 1'b1;
    idle("post_reset");

    // 1: commit of a mixed line
    send_str("SET V 00100", "t1");
    send(8'h0D, "t1_enter");
    chk("t1.line_hi", 256'(bus.line_out[255:168]), 256'(88'h5345542056203030313030));
    chk("t1.line_lo", 256'(bus.line_out[167:0]), 256'(0));
    chk("t1.pulse", 256'(bus.line_ready), 256'(1));
    idle("t1_after");

    // 2: upcasing
    send_str("fire", "t2");
    send(8'h0D, "t2_enter");
    chk("t2.line_hi", 256'(bus.line_out[255:224]), 256'(32'h46495245));
    idle("t2_after");

    // 3: backspace editing and underflow
    send_str("SEX", "t3");
    send(8'h08, "t3_bs");
    send_str("T", "t3");
    chk("t3.edit_hi", 256'(bus.edit_line[255:232]), 256'(24'h534554));
    for (int i = 0; i < 4; i++) send(8'h08, "t3_bs4");
    chk("t3.cursor0", 256'(bus.cursor), 256'(0));

    // 4: overflow and discarded line
    for (int i = 0; i < 33; i++) send(u8'(8'h30 + (i % 10)), "t4_fill");
    chk("t4.ovf", 256'(bus.overflow), 256'(1));
    chk("t4.cur32", 256'(bus.cursor), 256'(32));
    send(8'h0D, "t4_enter");
    chk("t4.no_pulse", 256'(bus.line_ready), 256'(0));
    idle("t4_after");

    // 5: empty enter, escape, back-to-back enter + char, double enter
    send(8'h0D, "t5_empty");
    send_str("SET", "t5");
    send(8'h1B, "t5_esc");
    send_str("GO", "t5");
    send(8'h0A, "t5_enter");
    send(8'h0D, "t5_enter2");
    send_str("B", "t5");
    send(8'h0D, "t5_enter3");
    send(8'h41, "t5_btb");
    chk("t5.slot0", 256'(bus.edit_line[255:248]), 256'(8'h41));
    send(8'h1B, "t5_clr");

    // 6: asynchronous reset mid-line and during COMMIT
    send_str("ABCDE", "t6");
    @(negedge clk);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_all("t6_rst_mid");
    @(negedge clk);
    resetn = 1'b1;
    send_str("XY", "t6");
    send(8'h0D, "t6_enter");
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_all("t6_rst_commit");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.char_in    = 8'h41;
      bus.char_valid = 1'b1;
      @(posedge clk);
      #1;
      check_all("t6_valid_in_rst");
    end
    @(negedge clk);
    bus.char_valid = 1'b0;
    resetn = 1'b1;
    idle("t6_release");

    // Random keystrokes against the model
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 80)      c = u8'($urandom_range(8'h20, 8'h7E));
      else if (r < 86) c = 8'h08;
      else if (r < 90) c = 8'h0D;
      else if (r < 92) c = 8'h0A;
      else if (r < 94) c = 8'h1B;
      else if (r < 97) c = u8'($urandom_range(8'h00, 8'h1F));
      else             c = u8'($urandom_range(8'h7F, 8'hFF));
      send(c, "rand");
      if ($urandom_range(0, 7) == 0) idle("rand_gap");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
